// File: rtl/mux_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data port arbiter.
// Imported by the arbiter, its hold timer and the port interface.
package mux_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } arb_state_e;

  localparam logic SEL_REQ0 = 1'b0;
  localparam logic SEL_REQ1 = 1'b1;

  // Round-robin pick: on a tie the side that was not served last wins.
  function automatic arb_state_e rr_pick(
    input logic r0,
    input logic r1,
    input logic last
  );
    arb_state_e s;
    s = ST_IDLE;
    if (r0 && r1) s = last ? ST_G0 : ST_G1;
    else if (r0)  s = ST_G0;
    else if (r1)  s = ST_G1;
    return s;
  endfunction

endpackage

// File: rtl/mux_port_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
// slave = arbiter side, master = requester/resource side.
interface mux_port_arbiter_if;

  logic req0;
  logic req1;
  logic done;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic busy;
  logic timeout_err;

  modport slave (
    input  req0, req1, done,
    output gnt0, gnt1, sel, busy, timeout_err
  );

  modport master (
    output req0, req1, done,
    input  gnt0, gnt1, sel, busy, timeout_err
  );

endinterface

// File: rtl/mux_port_arbiter_hold_timer.sv
// Counts cycles a grant has been held; saturates at MAX_HOLD.
// expired_o flags the last permitted cycle of a grant.
module mux_hold_timer #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on grant entry, otherwise count up to saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && cnt_q != SAT)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q >= LIM);

endmodule

// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter sharing one resource port between fetch and data.
// Grants are held until done, abandon, or a forced hold-limit release.
module mux_port_arbiter
  import mux_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_port_arbiter_if.slave    arb
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_q;
  logic       last_d;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       sel_q;
  logic       busy_q;
  logic       tmo_q;

  logic       expired;
  logic       xend;
  logic       tmo;
  logic       free;
  logic       start;
  logic       stay;

  // Decide transaction end, timeout and the next grant.
  always_comb begin
    xend   = 1'b0;
    tmo    = 1'b0;
    last_d = last_q;
    case (state_q)
      ST_G0: begin
        if (arb.done || !arb.req0) begin
          xend = 1'b1;
        end else if (expired) begin
          xend = 1'b1;
          tmo  = 1'b1;
        end
        if (xend) last_d = 1'b0;
      end
      ST_G1: begin
        if (arb.done || !arb.req1) begin
          xend = 1'b1;
        end else if (expired) begin
          xend = 1'b1;
          tmo  = 1'b1;
        end
        if (xend) last_d = 1'b1;
      end
      default: ;
    endcase
    free    = (state_q == ST_IDLE) || xend;
    state_d = free ? rr_pick(arb.req0, arb.req1, last_d)
                   : state_q;
    start   = free && (state_d != ST_IDLE);
    stay    = !free;
  end

  mux_hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (start),
    .enable_i  (stay),
    .expired_o (expired)
  );

  // FSM state, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= SEL_REQ0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == ST_G0);
      gnt1_q  <= (state_d == ST_G1);
      busy_q  <= (state_d != ST_IDLE);
      tmo_q   <= tmo;
      if (state_d == ST_G0)      sel_q <= SEL_REQ0;
      else if (state_d == ST_G1) sel_q <= SEL_REQ1;
    end
  end

  assign arb.gnt0        = gnt0_q;
  assign arb.gnt1        = gnt1_q;
  assign arb.sel         = sel_q;
  assign arb.busy        = busy_q;
  assign arb.timeout_err = tmo_q;

endmodule
